// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters,
// throttled by the FIFO full/almost_full flags and bounded per owner by MAX_BURST.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, OWN, STALL} state_t;

    state_t                state, nxt_state;
    logic [IW-1:0]         owner, nxt_owner;
    logic [IW-1:0]         rr_ptr, nxt_rr;
    logic [IW-1:0]         gnt_idx;
    logic [3:0]            burst_cnt, nxt_burst;
    logic                  wr_ok;
    logic                  accept;
    logic                  hold;
    logic [IW:0]           search;
    logic [DATA_WIDTH-1:0] gnt_data;

    // First valid requester after ptr (wrapping, ptr itself checked last); MSB = found.
    function automatic logic [IW:0] rr_search(input logic [NUM_REQ-1:0] valid,
                                               input logic [IW-1:0]      ptr);
        logic [IW:0]   res;
        logic [IW-1:0] cand;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (valid[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    // fifo_wr is last cycle's write, which the flags do not reflect yet.
    assign wr_ok = !fifo_full && !(fifo_almost_full && fifo_wr);

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= IW'(NUM_REQ - 1);
            burst_cnt <= '0;
            fifo_wr   <= 1'b0;
            fifo_data <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= nxt_state;
            owner     <= nxt_owner;
            rr_ptr    <= nxt_rr;
            burst_cnt <= nxt_burst;
            fifo_wr   <= accept;
            busy      <= (nxt_state != IDLE);
            if (accept) begin
                fifo_data <= gnt_data;
                grant_id  <= gnt_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        nxt_state = state;
        nxt_owner = owner;
        nxt_rr    = rr_ptr;
        nxt_burst = burst_cnt;
        gnt_idx   = owner;
        accept    = 1'b0;

        hold   = (state != IDLE) && req_valid[owner] && (burst_cnt < 4'(MAX_BURST));
        search = rr_search(req_valid, (state == IDLE) ? rr_ptr : owner);

        if (hold) begin
            if (wr_ok) begin
                accept    = 1'b1;
                nxt_burst = burst_cnt + 4'd1;
                nxt_state = OWN;
            end else begin
                nxt_state = STALL;
            end
        end else begin
            if (state != IDLE) nxt_rr = owner;
            if (search[IW]) begin
                nxt_owner = search[IW-1:0];
                gnt_idx   = search[IW-1:0];
                if (wr_ok) begin
                    accept    = 1'b1;
                    nxt_burst = 4'd1;
                    nxt_state = OWN;
                end else begin
                    nxt_burst = 4'd0;
                    nxt_state = STALL;
                end
            end else begin
                nxt_burst = 4'd0;
                nxt_state = IDLE;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept && rst_n) req_ready[gnt_idx] = 1'b1;
        gnt_data = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter placed in front of the async FIFO write side, in the wr_clk domain. It shares one FIFO write port (wr/data_in) among NUM_REQ requesters using per-requester valid/ready handshakes. It throttles on the FIFO's full and almost_full flags so the FIFO never overflows. A burst limit bounds how long any one requester holds the port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, FIFO data width
MAX_BURST, 4, max consecutive accepted words from one requester before rotation (1..15)

Ports:
wr_clk  in  1  write-domain clock (only clock)
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester data valid
req_data  in  NUM_REQ*DATA_WIDTH  packed data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] && req_ready[i]
fifo_full  in  1  FIFO full flag, wr_clk domain
fifo_almost_full  in  1  FIFO has exactly one free slot
fifo_wr  out  1  registered FIFO write strobe
fifo_data  out  DATA_WIDTH  registered FIFO write data
grant_id  out  $clog2(NUM_REQ)  index of requester whose word is on fifo_data
busy  out  1  high while an owner is held (state OWN or STALL)

Behaviour:
- Reset (rst_n low, async): fifo_wr=0, fifo_data=0, grant_id=0, busy=0, req_ready=0, state=IDLE, burst_cnt=0, rr_ptr=NUM_REQ-1 so the first search starts at requester 0.
- Write permission each cycle: wr_ok = !fifo_full && !(fifo_almost_full && fifo_wr). fifo_wr is the registered strobe from the previous cycle; this covers the 1-cycle flag update lag.
- req_ready is combinational: at most one bit set, only when wr_ok. An accepted word appears on fifo_data with fifo_wr=1 on the next cycle (latency 1). Otherwise fifo_wr=0 and fifo_data holds its last value.
- Requester rule: once req_valid is asserted, data must be held stable until accepted. The arbiter never grants a requester whose valid is low.
- States:
  - IDLE: no owner. Search req_valid starting at rr_ptr+1 with wrap-around. First valid requester becomes owner.
    - If wr_ok: accept in the same cycle, set burst_cnt=1, go to OWN.
    - If not wr_ok: take ownership without accepting, set burst_cnt=0, go to STALL.
  - OWN: owner valid, wr_ok, and burst_cnt<MAX_BURST: accept and increment burst_cnt.
    - Owner valid and !wr_ok: go to STALL; ownership and burst_cnt are retained.
    - Owner valid low, or burst_cnt==MAX_BURST: set rr_ptr=owner and rotate. Search from owner+1 (wrap) in the same cycle; the search may pick the old owner only if no other requester is valid, and then burst_cnt restarts at 1.
    - No valid requesters: go to IDLE.
  - STALL: no accepts. When wr_ok returns, go back to OWN behaviour in that same cycle, with the same owner and same burst_cnt.
    - If the owner drops valid while stalled, rotate as in OWN.
- Fairness: with all requesters continuously valid and wr_ok high, the accept order is 0×MAX_BURST, 1×MAX_BURST, …, wrapping around. There are no idle cycles between bursts.
- busy is registered and reflects the state after the clock edge.
- grant_id is registered together with fifo_data.
- Reset mid-burst: all outputs clear immediately on rst_n fall. A word accepted in the cycle of the reset edge is discarded. After release, arbitration restarts at requester 0.
- burst_cnt width is 4 bits; it saturates at MAX_BURST and never wraps.

Test Plan:
- Single requester: req_valid=4'b0100 with data 0x11,0x22,0x33 and fifo never full -> fifo_wr high for 3 cycles, each word one cycle after its accept. fifo_data 0x11,0x22,0x33; grant_id=2. After the 4th word (MAX_BURST=4) the same requester is re-granted with no gap.
- All 4 requesters always valid, FIFO never full, 16 words -> grant_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3; fifo_wr continuously high.
- Full backpressure: assert fifo_full mid-burst after 2 words from requester 1 -> req_ready=0 and fifo_wr=0 while full. On deassert, requester 1 resumes and gets exactly 2 more words before rotation to 2.
- Almost_full with back-to-back writes: fifo_almost_full=1 in a cycle where fifo_wr=1 -> req_ready=0 that cycle. The next cycle (fifo_wr=0, almost_full still 1) one word is accepted.
- Owner drops valid: requester 0 valid for 2 words then low, requester 3 valid -> rotation happens in the same cycle with no idle cycle. The next fifo_wr carries grant_id=3.
- Reset mid-operation: pull rst_n low during a burst from requester 2 -> fifo_wr, busy, req_ready and grant_id are 0 immediately. After release with all valid, the first grant goes to requester 0.
